mpi_send_arb: RTL

MPI_SEND_ARB -- requirements
Module: mpi_send_arb

---
 rtl/mpi_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/mpi_send_arb.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mpi_pkg.sv
// Shared definitions for the MPI send-channel arbiter.
//   DATA_WIDTH        payload width of one message beat
//   DEF_CREDIT_WIDTH  default width of a per-destination credit counter
//   state_e           output-register FSM states
package mpi_pkg;

  localparam int unsigned DATA_WIDTH       = 64;
  localparam int unsigned DEF_CREDIT_WIDTH = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot selector.
//   i_req     request vector
//   i_ptr     index where the search starts (highest priority)
//   o_grant_c one-hot-or-zero grant, combinational
module rr_arbiter #(
  parameter  int unsigned N     = 4,
  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant_c
);

  // Walk the requests starting at i_ptr, wrapping at N; first hit wins.
  always_comb begin : p_search
    logic             w_found;
    logic [PTR_W-1:0] w_idx;
    w_found   = 1'b0;
    w_idx     = '0;
    o_grant_c = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_idx = PTR_W'((32'(i_ptr) + k) % N);
      if (!w_found && i_req[w_idx]) begin
        o_grant_c[w_idx] = 1'b1;
        w_found          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mpi_send_arb.sv
// Credit-gated round-robin arbiter feeding a single registered MPI send channel.
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   req_valid/req_data/req_dest   per-requester message offer
//   req_ready                     combinational one-hot accept
//   snd_valid/data/dest/src       registered beat to the link, snd_ready handshake
//   cred_ret_valid/cred_ret_dest  one credit returned by a remote rank
//   cred_err                      sticky credit-overflow flag
// Optional build macro MPI_SEND_ARB_STATS_EN adds stat_sent / stat_stall counters.
module mpi_send_arb
  import mpi_pkg::*;
#(
  parameter  int unsigned NUM_REQ      = 4,
  parameter  int unsigned NUM_DEST     = 4,
  parameter  int unsigned CREDIT_WIDTH = DEF_CREDIT_WIDTH,
  parameter  int unsigned INIT_CREDITS = 1,
  localparam int unsigned DEST_W       = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1,
  localparam int unsigned SRC_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ*DEST_W-1:0]     req_dest,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          snd_valid,
  output logic [DATA_WIDTH-1:0]         snd_data,
  output logic [DEST_W-1:0]             snd_dest,
  output logic [SRC_W-1:0]              snd_src,
  input  logic                          snd_ready,
  input  logic                          cred_ret_valid,
  input  logic [DEST_W-1:0]             cred_ret_dest,
  output logic                          cred_err
`ifdef MPI_SEND_ARB_STATS_EN
  ,
  output logic [31:0]                   stat_sent,
  output logic [31:0]                   stat_stall
`endif
);

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [DATA_WIDTH-1:0]   r_snd_data;
  logic [DEST_W-1:0]       r_snd_dest;
  logic [SRC_W-1:0]        r_snd_src;
  logic [SRC_W-1:0]        r_rr_ptr;
  logic [CREDIT_WIDTH-1:0] r_credit [NUM_DEST];
  logic                    r_cred_err;

  logic [NUM_REQ-1:0]      w_elig;
  logic [NUM_REQ-1:0]      w_req;
  logic [NUM_REQ-1:0]      w_grant;
  logic                    w_can_grant;
  logic                    w_any_grant;
  logic [SRC_W-1:0]        w_win_src;
  logic [DEST_W-1:0]       w_win_dest;
  logic [DATA_WIDTH-1:0]   w_win_data;
  logic [NUM_DEST-1:0]     w_dec;
  logic [NUM_DEST-1:0]     w_inc;
  logic                    w_overflow;

  // Eligible: valid, destination exists, and that destination has credit.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_elig[i] = req_valid[i]
               && (32'(req_dest[i*DEST_W +: DEST_W]) < NUM_DEST)
               && (r_credit[req_dest[i*DEST_W +: DEST_W]] != '0);
    end
  end

  // Output register can take a new beat when empty or draining this cycle.
  assign w_can_grant = rst_n && ((r_state == ST_IDLE) || snd_ready);
  assign w_req       = w_can_grant ? w_elig : '0;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .i_req     (w_req),
    .i_ptr     (r_rr_ptr),
    .o_grant_c (w_grant)
  );

  assign req_ready   = w_grant;
  assign w_any_grant = |w_grant;

  // Winner payload mux.
  always_comb begin
    w_win_src  = '0;
    w_win_dest = '0;
    w_win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_win_src  = SRC_W'(i);
        w_win_dest = req_dest[i*DEST_W +: DEST_W];
        w_win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_any_grant) w_state_nxt = ST_BUSY;
      ST_BUSY: if (snd_ready && !w_any_grant) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output beat and round-robin pointer; both only move on a grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_snd_data <= '0;
      r_snd_dest <= '0;
      r_snd_src  <= '0;
      r_rr_ptr   <= '0;
    end else if (w_any_grant) begin
      r_snd_data <= w_win_data;
      r_snd_dest <= w_win_dest;
      r_snd_src  <= w_win_src;
      r_rr_ptr   <= (w_win_src == SRC_W'(NUM_REQ - 1)) ? '0 : w_win_src + SRC_W'(1);
    end
  end

  // Per-destination consume/return; a simultaneous pair cancels out.
  always_comb begin
    w_dec      = '0;
    w_inc      = '0;
    w_overflow = 1'b0;
    for (int d = 0; d < NUM_DEST; d++) begin
      w_dec[d] = w_any_grant && (w_win_dest == DEST_W'(d));
      w_inc[d] = cred_ret_valid && (cred_ret_dest == DEST_W'(d));
      if (w_inc[d] && !w_dec[d] && (r_credit[d] == CREDIT_WIDTH'(INIT_CREDITS)))
        w_overflow = 1'b1;
    end
  end

  // Credit counters; an over-return is dropped and flagged.
  always_ff @(posedge clk) begin
    for (int d = 0; d < NUM_DEST; d++) begin
      if (!rst_n)
        r_credit[d] <= CREDIT_WIDTH'(INIT_CREDITS);
      else if (w_dec[d] && !w_inc[d])
        r_credit[d] <= r_credit[d] - CREDIT_WIDTH'(1);
      else if (w_inc[d] && !w_dec[d] && (r_credit[d] != CREDIT_WIDTH'(INIT_CREDITS)))
        r_credit[d] <= r_credit[d] + CREDIT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_cred_err <= 1'b0;
    else        r_cred_err <= r_cred_err | w_overflow;
  end

  assign snd_valid = (r_state == ST_BUSY);
  assign snd_data  = r_snd_data;
  assign snd_dest  = r_snd_dest;
  assign snd_src   = r_snd_src;
  assign cred_err  = r_cred_err;

`ifdef MPI_SEND_ARB_STATS_EN
  logic [31:0] r_stat_sent;
  logic [31:0] r_stat_stall;

  // Wrapping activity counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat_sent  <= '0;
      r_stat_stall <= '0;
    end else begin
      if (snd_valid && snd_ready)     r_stat_sent  <= r_stat_sent + 32'd1;
      if (|req_valid && !w_any_grant) r_stat_stall <= r_stat_stall + 32'd1;
    end
  end

  assign stat_sent  = r_stat_sent;
  assign stat_stall = r_stat_stall;
`endif

endmodule
